fetch_unit: RTL and testbench

- Instruction fetch and PC sequencing stage that sits directly upstream of the instruction decoder.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Holds the fetched word stable on INST for the decoder during execute.
- Computes the next PC from the decoder's BS/OFF outputs and the ALU ZERO/NEG flags, and stops the machine on HALT.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit_branch_eval.sv | 31 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-select codes, opcode/function-select constants,
// fetch state encoding and the NOP instruction word.
package cpu_pkg;

    localparam logic [2:0] BS_EQ  = 3'b000;
    localparam logic [2:0] BS_NE  = 3'b001;
    localparam logic [2:0] BS_GEZ = 3'b010;
    localparam logic [2:0] BS_LTZ = 3'b011;
    localparam logic [2:0] BS_NB  = 3'b100;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BR   = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] FS_ADD  = 3'd0;
    localparam logic [2:0] FS_SUB  = 3'd1;
    localparam logic [2:0] FS_AND  = 3'd2;
    localparam logic [2:0] FS_OR   = 3'd3;
    localparam logic [2:0] FS_XOR  = 3'd4;
    localparam logic [2:0] FS_SHL  = 3'd5;
    localparam logic [2:0] FS_SHR  = 3'd6;
    localparam logic [2:0] FS_PASS = 3'd7;

    localparam logic [15:0] NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        STOP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and IMEM.
interface fetch_unit_if #(
    parameter int unsigned PC_W = 8
) ();
    logic [PC_W-1:0] IMEM_ADDR;
    logic            IMEM_REQ;
    logic [15:0]     IMEM_DATA;
    logic            IMEM_ACK;

    modport master (
        output IMEM_ADDR,
        output IMEM_REQ,
        input  IMEM_DATA,
        input  IMEM_ACK
    );

    modport slave (
        input  IMEM_ADDR,
        input  IMEM_REQ,
        output IMEM_DATA,
        output IMEM_ACK
    );
endinterface

// File: rtl/fetch_unit_branch_eval.sv
// Branch condition evaluation and next-PC arithmetic (modulo 2^PC_W).
module branch_eval
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [2:0]      bs_i,
    input  logic            zero_i,
    input  logic            neg_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [5:0]      off_i,
    output logic [PC_W-1:0] next_pc_o
);
    logic            taken;
    logic [PC_W-1:0] off_ext;

    always_comb begin
        taken = 1'b0;
        case (bs_i)
            BS_EQ:   taken = zero_i;
            BS_NE:   taken = ~zero_i;
            BS_GEZ:  taken = ~neg_i;
            BS_LTZ:  taken = neg_i;
            default: taken = 1'b0;
        endcase
    end

    assign off_ext   = PC_W'($signed(off_i));
    assign next_pc_o = pc_i + PC_W'(1) + (taken ? off_ext : '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC sequencing stage: fetches over the IMEM handshake, holds INST for
// execute, and advances the PC or stops on HALT.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned    PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    fetch_unit_if.master    imem,
    output logic [15:0]     INST,
    output logic            INST_VALID,
    output logic            COMMIT,
    input  logic            STALL,
    input  logic [2:0]      BS,
    input  logic [5:0]      OFF,
    input  logic            ZERO,
    input  logic            NEG,
    input  logic            HALT,
    output logic [PC_W-1:0] PC,
    output logic            HALTED
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     inst_q, inst_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic [PC_W-1:0] next_pc;

    branch_eval #(
        .PC_W(PC_W)
    ) u_branch_eval (
        .bs_i     (BS),
        .zero_i   (ZERO),
        .neg_i    (NEG),
        .pc_i     (pc_q),
        .off_i    (OFF),
        .next_pc_o(next_pc)
    );

    // req_q is low only in the first FETCH cycle after reset, so an ack
    // left over from before reset is never sampled.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem.IMEM_ACK) begin
                    inst_d  = imem.IMEM_DATA;
                    state_d = EXEC;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            EXEC: begin
                if (!STALL) begin
                    valid_d = 1'b0;
                    if (HALT) begin
                        state_d  = STOP;
                        halted_d = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
            STOP: begin
            end
            default: begin
                state_d = FETCH;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem.IMEM_ADDR = pc_q;
    assign imem.IMEM_REQ  = req_q;
    assign INST           = inst_q;
    assign INST_VALID     = valid_q;
    assign COMMIT         = valid_q & ~STALL;
    assign PC             = pc_q;
    assign HALTED         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against an arithmetic PC/branch model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, zero, neg, halt;
    logic [2:0]  bs;
    logic [5:0]  off;
    logic [15:0] inst;
    logic        inst_valid, commit, halted;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    int model_pc;

    // observations of the last instruction driven by do_instr
    int          obs_addr, obs_exp_pc, obs_req_cycles, obs_commits;
    logic [15:0] obs_inst;
    bit          obs_started, obs_addr_stable, obs_valid_early, obs_valid_at_exec;
    bit          obs_valid_all, obs_pc_hold, obs_req_low, obs_inst_hold;
    bit          obs_req_after, obs_valid_after;
    logic [7:0]  obs_pc;

    fetch_unit_if #(.PC_W(8)) imem ();

    fetch_unit #(
        .PC_W    (8),
        .RESET_PC(8'd0)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .imem      (imem),
        .INST      (inst),
        .INST_VALID(inst_valid),
        .COMMIT    (commit),
        .STALL     (stall),
        .BS        (bs),
        .OFF       (off),
        .ZERO      (zero),
        .NEG       (neg),
        .HALT      (halt),
        .PC        (pc),
        .HALTED    (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic int ref_next(int cur, int bsel, logic [5:0] o, bit z, bit n, bit h);
        int  offv;
        bit  taken;
        offv  = (o >= 6'd32) ? int'(o) - 64 : int'(o);
        taken = (bsel == 0 && z) || (bsel == 1 && !z) || (bsel == 2 && !n) || (bsel == 3 && n);
        if (h) return cur;
        return (((cur + 1 + (taken ? offv : 0)) % 256) + 256) % 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input int delay, input int stall_n, input logic [2:0] b,
                            input logic [5:0] o, input bit z, input bit n, input bit h);
        int guard = 0;
        obs_started = 1;
        while (imem.IMEM_REQ !== 1'b1 && guard < 4) begin
            tick();
            guard++;
        end
        if (imem.IMEM_REQ !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout got REQ=%b exp 1", imem.IMEM_REQ);
            obs_started = 0;
            return;
        end
        obs_addr        = int'(imem.IMEM_ADDR);
        obs_addr_stable = 1;
        obs_valid_early = 0;
        obs_req_cycles  = 0;
        for (int k = 0; k <= delay; k++) begin
            if (imem.IMEM_ADDR !== 8'(obs_addr) || imem.IMEM_REQ !== 1'b1) obs_addr_stable = 0;
            if (inst_valid) obs_valid_early = 1;
            obs_req_cycles++;
            imem.IMEM_ACK  = (k == delay);
            imem.IMEM_DATA = (k == delay) ? mem[obs_addr] : 16'($urandom);
            bs    = 3'($urandom);
            zero  = 1'($urandom);
            neg   = 1'($urandom);
            halt  = 1'($urandom);
            stall = 1'($urandom);
            tick();
        end
        obs_inst          = inst;
        obs_valid_at_exec = inst_valid;
        obs_valid_all     = 1;
        obs_pc_hold       = 1;
        obs_req_low       = 1;
        obs_inst_hold     = 1;
        obs_commits       = 0;
        for (int s = 0; s <= stall_n; s++) begin
            stall = (s < stall_n);
            bs    = b;
            off   = o;
            neg   = n;
            halt  = h;
            zero  = (s < stall_n) ? 1'($urandom) : z;
            imem.IMEM_ACK  = 1'($urandom);
            imem.IMEM_DATA = 16'($urandom);
            #1;
            if (!inst_valid) obs_valid_all = 0;
            if (commit) obs_commits++;
            if (pc !== 8'(obs_addr)) obs_pc_hold = 0;
            if (imem.IMEM_REQ) obs_req_low = 0;
            if (inst !== obs_inst) obs_inst_hold = 0;
            @(posedge clk);
            #1;
        end
        imem.IMEM_ACK   = 1'b0;
        stall           = 1'b0;
        halt            = 1'b0;
        bs              = 3'b100;
        obs_pc          = pc;
        obs_req_after   = imem.IMEM_REQ;
        obs_valid_after = inst_valid;
        obs_exp_pc      = ref_next(model_pc, int'(b), o, z, n, h);
        model_pc        = obs_exp_pc;
    endtask

    task automatic goto_pc(input int target);
        int d;
        for (int i = 0; i < 20 && model_pc != target; i++) begin
            d = (((target - model_pc - 1) % 256) + 256) % 256;
            if (d > 127) d -= 256;
            if (d > 31) d = 31;
            if (d < -32) d = -32;
            do_instr(0, 0, 3'b000, 6'(d), 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_pc !== 8'(obs_exp_pc)) begin
                errors++;
                $display("FAIL goto_pc got %0d exp %0d", obs_pc, obs_exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 8'd0 || inst !== 16'h0000 || inst_valid !== 1'b0 || commit !== 1'b0 ||
            imem.IMEM_REQ !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pc=%0d inst=%h v=%b c=%b req=%b h=%b exp 0 0000 0 0 0 0",
                     pc, inst, inst_valid, commit, imem.IMEM_REQ, halted);
        end
        rst = 1'b0;
        model_pc = 0;
        tick();
        checks++;
        if (imem.IMEM_REQ !== 1'b1 || imem.IMEM_ADDR !== 8'd0) begin
            errors++;
            $display("FAIL reset_first_req got req=%b addr=%0d exp 1 0", imem.IMEM_REQ, imem.IMEM_ADDR);
        end
    endtask

    task automatic test_sequential();
        for (int a = 0; a < 4; a++) begin
            do_instr(0, 0, 3'b100, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            checks++;
            if (obs_addr != a || obs_inst !== mem[a] || obs_commits != 1 || !obs_valid_at_exec ||
                !obs_req_after || obs_valid_after) begin
                errors++;
                $display("FAIL seq_instr%0d got addr=%0d inst=%h commits=%0d vexec=%b reqnext=%b vnext=%b exp %0d %h 1 1 1 0",
                         a, obs_addr, obs_inst, obs_commits, obs_valid_at_exec, obs_req_after,
                         obs_valid_after, a, mem[a]);
            end
        end
        checks++;
        if (obs_pc !== 8'd4) begin
            errors++;
            $display("FAIL seq_pc got %0d exp 4", obs_pc);
        end
    endtask

    task automatic test_delayed_ack();
        goto_pc(5);
        do_instr(3, 0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_addr != 5 || !obs_addr_stable || obs_req_cycles != 4) begin
            errors++;
            $display("FAIL delay_addr_hold got addr=%0d stable=%b cycles=%0d exp 5 1 4",
                     obs_addr, obs_addr_stable, obs_req_cycles);
        end
        checks++;
        if (obs_valid_early || !obs_valid_at_exec || obs_inst !== mem[5]) begin
            errors++;
            $display("FAIL delay_inst_load got early=%b vexec=%b inst=%h exp 0 1 %h",
                     obs_valid_early, obs_valid_at_exec, obs_inst, mem[5]);
        end
    endtask

    task automatic test_branches();
        logic [2:0] tb_bs  [4] = '{3'b000, 3'b000, 3'b011, 3'b100};
        logic [5:0] tb_off [4] = '{6'b111100, 6'b111100, 6'd5, 6'd5};
        bit         tb_z   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit         tb_n   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int         tb_exp [4] = '{7, 11, 16, 11};
        for (int i = 0; i < 4; i++) begin
            goto_pc(10);
            do_instr(0, 0, tb_bs[i], tb_off[i], tb_z[i], tb_n[i], 1'b0);
            checks++;
            if (obs_pc !== 8'(tb_exp[i])) begin
                errors++;
                $display("FAIL branch_case%0d got pc=%0d exp %0d", i, obs_pc, tb_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        goto_pc(255);
        do_instr(0, 0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pc !== 8'd0) begin
            errors++;
            $display("FAIL wrap_up got pc=%0d exp 0", obs_pc);
        end
        goto_pc(2);
        do_instr(0, 0, 3'b000, 6'b111000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_pc !== 8'd251) begin
            errors++;
            $display("FAIL wrap_down got pc=%0d exp 251", obs_pc);
        end
        goto_pc(40);
        do_instr(0, 0, 3'b010, 6'b111111, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pc !== 8'd40) begin
            errors++;
            $display("FAIL branch_self got pc=%0d exp 40", obs_pc);
        end
    endtask

    task automatic test_stall();
        goto_pc(30);
        do_instr(0, 3, 3'b001, 6'd4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (!obs_pc_hold || !obs_valid_all || !obs_inst_hold || !obs_req_low) begin
            errors++;
            $display("FAIL stall_hold got pchold=%b vall=%b insthold=%b reqlow=%b exp 1 1 1 1",
                     obs_pc_hold, obs_valid_all, obs_inst_hold, obs_req_low);
        end
        checks++;
        if (obs_commits != 1 || obs_pc !== 8'd35) begin
            errors++;
            $display("FAIL stall_release got commits=%0d pc=%0d exp 1 35", obs_commits, obs_pc);
        end
    endtask

    task automatic test_random();
        logic [2:0] b;
        logic [5:0] o;
        int         exp_addr;
        for (int i = 0; i < 40; i++) begin
            b = 3'($urandom);
            o = 6'($urandom);
            exp_addr = model_pc;
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), b, o,
                     1'($urandom), 1'($urandom), 1'b0);
            checks++;
            if (obs_addr != exp_addr || obs_inst !== mem[exp_addr] || obs_commits != 1 ||
                obs_pc !== 8'(obs_exp_pc) || !obs_inst_hold) begin
                errors++;
                $display("FAIL rand%0d got addr=%0d inst=%h commits=%0d pc=%0d hold=%b exp %0d %h 1 %0d 1",
                         i, obs_addr, obs_inst, obs_commits, obs_pc, obs_inst_hold,
                         exp_addr, mem[exp_addr], obs_exp_pc);
            end
        end
    endtask

    task automatic test_halt();
        bit stop_ok = 1;
        goto_pc(20);
        do_instr(0, 2, 3'b000, 6'd5, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_pc !== 8'd20 || obs_commits != 1) begin
            errors++;
            $display("FAIL halt_commit got pc=%0d commits=%0d exp 20 1", obs_pc, obs_commits);
        end
        for (int i = 0; i < 8; i++) begin
            imem.IMEM_ACK  = 1'($urandom);
            imem.IMEM_DATA = 16'($urandom);
            bs   = 3'($urandom);
            zero = 1'($urandom);
            #1;
            if (halted !== 1'b1 || imem.IMEM_REQ !== 1'b0 || inst_valid !== 1'b0 ||
                commit !== 1'b0 || pc !== 8'd20 || inst !== mem[20]) stop_ok = 0;
            tick();
        end
        imem.IMEM_ACK = 1'b0;
        checks++;
        if (!stop_ok) begin
            errors++;
            $display("FAIL stop_state got h=%b req=%b v=%b c=%b pc=%0d inst=%h exp 1 0 0 0 20 %h",
                     halted, imem.IMEM_REQ, inst_valid, commit, pc, inst, mem[20]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_pc = 0;
        checks++;
        if (pc !== 8'd0 || halted !== 1'b0 || inst !== 16'h0000) begin
            errors++;
            $display("FAIL halt_reset got pc=%0d h=%b inst=%h exp 0 0 0000", pc, halted, inst);
        end
        do_instr(0, 0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_addr != 0 || obs_inst !== mem[0] || obs_pc !== 8'd1) begin
            errors++;
            $display("FAIL halt_resume got addr=%0d inst=%h pc=%0d exp 0 %h 1", obs_addr, obs_inst, obs_pc, mem[0]);
        end
    endtask

    task automatic test_reset_midfetch();
        goto_pc(40);
        imem.IMEM_ACK = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (imem.IMEM_REQ !== 1'b0 || inst !== 16'h0000) begin
            errors++;
            $display("FAIL midfetch_reset got req=%b inst=%h exp 0 0000", imem.IMEM_REQ, inst);
        end
        rst = 1'b0;
        model_pc = 0;
        imem.IMEM_ACK  = 1'b1;
        imem.IMEM_DATA = 16'hBEEF;
        tick();
        imem.IMEM_ACK = 1'b0;
        checks++;
        if (inst !== 16'h0000 || inst_valid !== 1'b0 || imem.IMEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL stale_ack got inst=%h v=%b req=%b exp 0000 0 1", inst, inst_valid, imem.IMEM_REQ);
        end
        do_instr(1, 0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_addr != 0 || obs_inst !== mem[0]) begin
            errors++;
            $display("FAIL midfetch_resume got addr=%0d inst=%h exp 0 %h", obs_addr, obs_inst, mem[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 4) ? {4'h1, 12'($urandom)} : (16'($urandom) | 16'h0100);
        end
        rst   = 1'b1;
        stall = 1'b0;
        zero  = 1'b0;
        neg   = 1'b0;
        halt  = 1'b0;
        bs    = 3'b100;
        off   = 6'd0;
        imem.IMEM_ACK  = 1'b0;
        imem.IMEM_DATA = 16'h0000;
        model_pc = 0;
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_branches();
        test_wrap();
        test_stall();
        test_random();
        test_halt();
        test_reset_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
